// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku propagation front-end.
// Optional build macro used by sudoku_propagator: SUDOKU_HIDDEN_SINGLE_EN.
package sudoku_pkg;

  typedef enum logic [1:0] {IDLE, CAND, ASSIGN, DONE} solver_state_e;

  typedef enum logic [1:0] {
    SOLVED  = 2'd0,
    STUCK   = 2'd1,
    CONTRA  = 2'd2,
    TIMEOUT = 2'd3
  } solve_status_e;

  // Widest candidate mask the helpers accept (BOX up to 8).
  localparam int MAX_SIDE = 64;

  function automatic int box_idx(input int r, input int c, input int box);
    return (r / box) * box + (c / box);
  endfunction

  // Lowest set bit k maps to value k+1; zero mask maps to 0.
  function automatic int onehot2val(input logic [MAX_SIDE-1:0] oh);
    int v;
    v = 0;
    for (int k = MAX_SIDE - 1; k >= 0; k--) begin
      if (oh[k]) v = k + 1;
    end
    return v;
  endfunction

endpackage

// File: rtl/unit_mask_dup.sv
// Used-value mask and duplicate detection for one row, column or box.
module unit_mask_dup
  import sudoku_pkg::*;
#(
  parameter int SIDE = 9,
  parameter int VW   = 4
) (
  input  logic [SIDE*VW-1:0] vals,
  output logic [SIDE-1:0]    used,
  output logic               dup
);

  always_comb begin
    used = '0;
    dup  = 1'b0;
    for (int k = 0; k < SIDE; k++) begin
      for (int v = 1; v <= SIDE; v++) begin
        if (vals[k*VW +: VW] == VW'(v)) begin
          if (used[v-1]) dup = 1'b1;
          used[v-1] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sudoku_propagator.sv
// Iterative naked-single constraint propagation over a BOX^2 x BOX^2 grid.
// Define SUDOKU_HIDDEN_SINGLE_EN to also assign hidden singles when no naked single exists.
module sudoku_propagator
  import sudoku_pkg::*;
#(
  parameter int BOX      = 3,
  parameter int VW       = $clog2(BOX*BOX+1),
  parameter int MAX_ITER = 32,
  parameter int IW       = $clog2(MAX_ITER+1)
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BOX**4*VW-1:0]        in_grid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BOX**4*VW-1:0]        out_grid,
  output logic [1:0]                  out_status,
  output logic [IW-1:0]               out_iter
);

  localparam int SIDE  = BOX * BOX;
  localparam int NCELL = SIDE * SIDE;

  solver_state_e   state;
  logic [VW-1:0]   grid [NCELL];
  logic [SIDE-1:0] cand [NCELL];
  logic            any_dup;
  logic [IW-1:0]   iter;

  logic [SIDE-1:0] row_used [SIDE];
  logic [SIDE-1:0] col_used [SIDE];
  logic [SIDE-1:0] box_used [SIDE];
  logic            row_dup  [SIDE];
  logic            col_dup  [SIDE];
  logic            box_dup  [SIDE];

  for (genvar u = 0; u < SIDE; u++) begin : g_unit
    logic [SIDE*VW-1:0] rv, cv, bv;
    for (genvar k = 0; k < SIDE; k++) begin : g_cell
      assign rv[k*VW +: VW] = grid[u*SIDE + k];
      assign cv[k*VW +: VW] = grid[k*SIDE + u];
      assign bv[k*VW +: VW] = grid[((u/BOX)*BOX + k/BOX)*SIDE + (u%BOX)*BOX + k%BOX];
    end
    unit_mask_dup #(.SIDE(SIDE), .VW(VW)) u_row (.vals(rv), .used(row_used[u]), .dup(row_dup[u]));
    unit_mask_dup #(.SIDE(SIDE), .VW(VW)) u_col (.vals(cv), .used(col_used[u]), .dup(col_dup[u]));
    unit_mask_dup #(.SIDE(SIDE), .VW(VW)) u_box (.vals(bv), .used(box_used[u]), .dup(box_dup[u]));
  end

  logic [SIDE-1:0] cand_nxt [NCELL];
  logic            dup_nxt;

  // Out-of-range cell values are folded into the duplicate flag.
  always_comb begin
    dup_nxt = 1'b0;
    for (int u = 0; u < SIDE; u++) begin
      dup_nxt = dup_nxt | row_dup[u] | col_dup[u] | box_dup[u];
    end
    for (int i = 0; i < NCELL; i++) begin
      if (grid[i] > VW'(SIDE)) dup_nxt = 1'b1;
      if (grid[i] == '0)
        cand_nxt[i] = ~(row_used[i/SIDE] | col_used[i%SIDE] |
                        box_used[box_idx(i/SIDE, i%SIDE, BOX)]);
      else
        cand_nxt[i] = '0;
    end
  end

  logic            any_empty, any_zero, any_naked, any_hidden;
  logic [SIDE-1:0] naked [NCELL];
  logic [SIDE-1:0] hid   [NCELL];

  always_comb begin
    any_empty = 1'b0;
    any_zero  = 1'b0;
    any_naked = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      naked[i] = '0;
      if (grid[i] == '0) begin
        any_empty = 1'b1;
        if (cand[i] == '0) begin
          any_zero = 1'b1;
        end else if ((cand[i] & (cand[i] - SIDE'(1))) == '0) begin
          naked[i]  = cand[i];
          any_naked = 1'b1;
        end
      end
    end
  end

`ifdef SUDOKU_HIDDEN_SINGLE_EN
  logic [SIDE-1:0] r_seen [SIDE], r_two [SIDE];
  logic [SIDE-1:0] c_seen [SIDE], c_two [SIDE];
  logic [SIDE-1:0] b_seen [SIDE], b_two [SIDE];

  // A value seen once but never twice in a unit is a hidden single there.
  always_comb begin
    for (int u = 0; u < SIDE; u++) begin
      r_seen[u] = '0; r_two[u] = '0;
      c_seen[u] = '0; c_two[u] = '0;
      b_seen[u] = '0; b_two[u] = '0;
    end
    for (int i = 0; i < NCELL; i++) begin
      r_two[i/SIDE]  = r_two[i/SIDE] | (r_seen[i/SIDE] & cand[i]);
      r_seen[i/SIDE] = r_seen[i/SIDE] | cand[i];
      c_two[i%SIDE]  = c_two[i%SIDE] | (c_seen[i%SIDE] & cand[i]);
      c_seen[i%SIDE] = c_seen[i%SIDE] | cand[i];
      b_two[box_idx(i/SIDE, i%SIDE, BOX)]  = b_two[box_idx(i/SIDE, i%SIDE, BOX)] |
                                             (b_seen[box_idx(i/SIDE, i%SIDE, BOX)] & cand[i]);
      b_seen[box_idx(i/SIDE, i%SIDE, BOX)] = b_seen[box_idx(i/SIDE, i%SIDE, BOX)] | cand[i];
    end
    any_hidden = 1'b0;
    for (int i = 0; i < NCELL; i++) begin
      hid[i] = cand[i] & ((r_seen[i/SIDE] & ~r_two[i/SIDE]) |
                          (c_seen[i%SIDE] & ~c_two[i%SIDE]) |
                          (b_seen[box_idx(i/SIDE, i%SIDE, BOX)] &
                           ~b_two[box_idx(i/SIDE, i%SIDE, BOX)]));
      if (hid[i] != '0) any_hidden = 1'b1;
    end
  end
`else
  always_comb begin
    any_hidden = 1'b0;
    for (int i = 0; i < NCELL; i++) hid[i] = '0;
  end
`endif

  logic          fin;
  solve_status_e fin_st;

  always_comb begin
    fin    = 1'b1;
    fin_st = SOLVED;
    if (!any_empty && !any_dup)         fin_st = SOLVED;
    else if (any_dup || any_zero)       fin_st = CONTRA;
    else if (!any_naked && !any_hidden) fin_st = STUCK;
    else if (iter == IW'(MAX_ITER))     fin_st = TIMEOUT;
    else                                fin    = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_grid   <= '0;
      out_status <= 2'd0;
      out_iter   <= '0;
      any_dup    <= 1'b0;
      iter       <= '0;
      for (int i = 0; i < NCELL; i++) begin
        grid[i] <= '0;
        cand[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < NCELL; i++) grid[i] <= in_grid[i*VW +: VW];
            iter     <= '0;
            in_ready <= 1'b0;
            state    <= CAND;
          end
        end
        CAND: begin
          for (int i = 0; i < NCELL; i++) cand[i] <= cand_nxt[i];
          any_dup <= dup_nxt;
          state   <= ASSIGN;
        end
        ASSIGN: begin
          if (fin) begin
            for (int i = 0; i < NCELL; i++) out_grid[i*VW +: VW] <= grid[i];
            out_status <= fin_st;
            out_iter   <= iter;
            state      <= DONE;
          end else begin
            // Naked singles win; hidden singles apply only when none exist.
            for (int i = 0; i < NCELL; i++) begin
              if (any_naked) begin
                if (naked[i] != '0) grid[i] <= VW'(onehot2val(MAX_SIDE'(naked[i])));
              end else if (hid[i] != '0) begin
                grid[i] <= VW'(onehot2val(MAX_SIDE'(hid[i])));
              end
            end
            iter  <= iter + IW'(1);
            state <= CAND;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
